// File: rtl/sort_pkg.sv
// Shared state encoding and helpers for the sorting-network batch controller.
package sort_pkg;

   typedef enum logic [1:0] {
      StLoad,
      StIssue,
      StWait,
      StDrain
   } sort_state_e;

   localparam int unsigned MaxDataWidth = 256;

   // Value that sorts to the tail: max when ascending, min when descending.
   function automatic logic [MaxDataWidth-1:0] pad_value(input bit          is_signed,
                                                         input bit          ascending,
                                                         input int unsigned data_width);
      logic [MaxDataWidth-1:0] v;
      v = '0;
      for (int i = 0; i < int'(MaxDataWidth); i++) begin
         if (i < int'(data_width)) begin
            v[i] = is_signed ? ((i == int'(data_width) - 1) ^ ascending) : ascending;
         end
      end
      return v;
   endfunction

   function automatic int unsigned slice_lsb(input int unsigned idx,
                                             input int unsigned data_width);
      return idx * data_width;
   endfunction

endpackage

// File: rtl/sort_result_buf.sv
// Result register file: parallel load of the whole sorted vector, one indexed read port.
module sort_result_buf
   import sort_pkg::*;
#(
   parameter int unsigned IDX_WIDTH  = 7,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  load,
   input  logic [DATA_WIDTH*(2**IDX_WIDTH)-1:0]  load_data,
   input  logic [IDX_WIDTH-1:0]                  rd_idx,
   output logic [DATA_WIDTH-1:0]                 rd_data
);

   localparam int unsigned Entries = 2**IDX_WIDTH;

   logic [DATA_WIDTH-1:0] y_words [Entries];
   logic [DATA_WIDTH-1:0] mem_q   [Entries];

   for (genvar j = 0; j < Entries; j++) begin : g_unpack
      assign y_words[j] = load_data[slice_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else if (load) begin
         mem_q <= y_words;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sort_batch_ctrl.sv
// Batch sequencer for a parallel sorting network: load, issue, wait for result, drain.
module sort_batch_ctrl
   import sort_pkg::*;
#(
   parameter int unsigned LOG_INPUT_NUM  = 7,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          SIGNED         = 1'b0,
   parameter bit          ASCENDING      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [DATA_WIDTH-1:0]                     in_data,
   input  logic                                      in_valid,
   input  logic                                      in_last,
   output logic                                      in_ready,
   output logic [DATA_WIDTH-1:0]                     out_data,
   output logic                                      out_valid,
   output logic                                      out_last,
   input  logic                                      out_ready,
   output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  srt_x,
   output logic                                      srt_x_valid,
   input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  srt_y,
   input  logic                                      srt_y_valid,
   output logic                                      busy,
   output logic                                      timeout_err
);

   localparam int unsigned NumSlots = 2**LOG_INPUT_NUM;
   localparam int unsigned CntWidth = LOG_INPUT_NUM + 1;
   localparam int unsigned TmrWidth = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [MaxDataWidth-1:0] PadFull = pad_value(SIGNED, ASCENDING, DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0]   Pad     = PadFull[DATA_WIDTH-1:0];
   localparam logic [CntWidth-1:0]     LastIdx = CntWidth'(NumSlots - 1);
   localparam logic [TmrWidth-1:0]     TmrLast = TmrWidth'(TIMEOUT_CYCLES - 1);

   sort_state_e           state_q, state_d;
   logic [CntWidth-1:0]   ld_cnt_q, ld_cnt_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [CntWidth-1:0]   rd_idx_q, rd_idx_d;
   logic [TmrWidth-1:0]   timer_q, timer_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [DATA_WIDTH-1:0] slots_q [NumSlots];
   logic [DATA_WIDTH-1:0] slots_d [NumSlots];

   logic                  buf_load;
   logic [DATA_WIDTH-1:0] buf_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StLoad;
         ld_cnt_q      <= '0;
         cnt_q         <= '0;
         rd_idx_q      <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         slots_q       <= '{default: Pad};
      end else begin
         state_q       <= state_d;
         ld_cnt_q      <= ld_cnt_d;
         cnt_q         <= cnt_d;
         rd_idx_q      <= rd_idx_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         slots_q       <= slots_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ld_cnt_d      = ld_cnt_q;
      cnt_d         = cnt_q;
      rd_idx_d      = rd_idx_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      slots_d       = slots_q;
      buf_load      = 1'b0;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      out_last      = 1'b0;
      out_data      = '0;
      srt_x_valid   = 1'b0;

      unique case (state_q)
         StLoad: begin
            in_ready = 1'b1;
            if (in_valid) begin
               slots_d[ld_cnt_q[LOG_INPUT_NUM-1:0]] = in_data;
               ld_cnt_d = ld_cnt_q + 1'b1;
               if (in_last || (ld_cnt_q == LastIdx)) begin
                  cnt_d   = ld_cnt_q + 1'b1;
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            srt_x_valid = 1'b1;
            timer_d     = '0;
            // A zero-latency sorter answers in the issue cycle itself.
            if (srt_y_valid) begin
               buf_load = 1'b1;
               rd_idx_d = '0;
               state_d  = StDrain;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (srt_y_valid) begin
               buf_load = 1'b1;
               rd_idx_d = '0;
               state_d  = StDrain;
            end else if (timer_q == TmrLast) begin
               timeout_err_d = 1'b1;
               slots_d       = '{default: Pad};
               ld_cnt_d      = '0;
               state_d       = StLoad;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StDrain: begin
            out_valid = 1'b1;
            out_data  = buf_rd_data;
            out_last  = (rd_idx_q == cnt_q - 1'b1);
            if (out_ready) begin
               if (out_last) begin
                  slots_d  = '{default: Pad};
                  ld_cnt_d = '0;
                  rd_idx_d = '0;
                  state_d  = StLoad;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   for (genvar j = 0; j < NumSlots; j++) begin : g_pack
      assign srt_x[slice_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = slots_q[j];
   end

   assign busy        = !((state_q == StLoad) && (ld_cnt_q == '0));
   assign timeout_err = timeout_err_q;

   sort_result_buf #(
      .IDX_WIDTH  (LOG_INPUT_NUM),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_result_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_data (srt_y),
      .rd_idx    (rd_idx_q[LOG_INPUT_NUM-1:0]),
      .rd_data   (buf_rd_data)
   );

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Directed bench: unsigned ascending instance with a latency-3 sorter model, plus a signed
// descending instance driven by hand.
module tb_sort_batch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Unsigned, ascending, N=4, short timeout.
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic [31:0]  out_data;
   logic         out_valid, out_last;
   logic         out_ready = 1'b1;
   logic [127:0] srt_x, srt_y;
   logic         srt_x_valid, srt_y_valid, busy, timeout_err;

   sort_batch_ctrl #(
      .LOG_INPUT_NUM  (2),
      .DATA_WIDTH     (32),
      .SIGNED         (1'b0),
      .ASCENDING      (1'b1),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .srt_x       (srt_x),
      .srt_x_valid (srt_x_valid),
      .srt_y       (srt_y),
      .srt_y_valid (srt_y_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Signed, descending, N=4.
   logic [31:0]  s_in_data = '0;
   logic         s_in_valid = 1'b0, s_in_last = 1'b0, s_in_ready;
   logic [31:0]  s_out_data;
   logic         s_out_valid, s_out_last;
   logic         s_out_ready = 1'b1;
   logic [127:0] s_srt_x;
   logic [127:0] s_srt_y = '0;
   logic         s_srt_x_valid, s_busy, s_timeout_err;
   logic         s_srt_y_valid = 1'b0;

   sort_batch_ctrl #(
      .LOG_INPUT_NUM  (2),
      .DATA_WIDTH     (32),
      .SIGNED         (1'b1),
      .ASCENDING      (1'b0),
      .TIMEOUT_CYCLES (1023)
   ) dut_s (
      .clk         (clk),
      .rst         (rst),
      .in_data     (s_in_data),
      .in_valid    (s_in_valid),
      .in_last     (s_in_last),
      .in_ready    (s_in_ready),
      .out_data    (s_out_data),
      .out_valid   (s_out_valid),
      .out_last    (s_out_last),
      .out_ready   (s_out_ready),
      .srt_x       (s_srt_x),
      .srt_x_valid (s_srt_x_valid),
      .srt_y       (s_srt_y),
      .srt_y_valid (s_srt_y_valid),
      .busy        (s_busy),
      .timeout_err (s_timeout_err)
   );

   // Latency-3 ascending unsigned sorter model.
   logic         model_on = 1'b1;
   int           lat = 0;
   int           xv_pulses = 0;
   logic [127:0] y_hold = '0;

   function automatic logic [127:0] sort4(input logic [127:0] x);
      logic [31:0] w [4];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = x[32*i +: 32];
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (w[j] > w[j+1]) begin
               t = w[j]; w[j] = w[j+1]; w[j+1] = t;
            end
         end
      end
      return {w[3], w[2], w[1], w[0]};
   endfunction

   always @(posedge clk) begin
      if (srt_x_valid) xv_pulses <= xv_pulses + 1;
      if (model_on && srt_x_valid) begin
         y_hold <= sort4(srt_x);
         lat    <= 3;
      end else if (lat != 0) begin
         lat <= lat - 1;
      end
   end
   assign srt_y_valid = (lat == 1);
   assign srt_y       = y_hold;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired, got timeout expected event", name);
   endtask

   typedef struct packed {
      logic [127:0] din;    // word i at [32i +: 32]
      logic [2:0]   n;
      logic [127:0] exp_x;
      logic [127:0] dout;
      logic         stall;
   } vec_t;

   localparam logic [127:0] PadU = {4{32'hFFFF_FFFF}};

   vec_t vecs [6];

   task automatic run_batch(input vec_t v, input logic exp_err);
      int          k, p, guard, pulses0;
      logic [31:0] prev;
      logic        stalled;
      pulses0 = xv_pulses;
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
      for (int i = 0; i < int'(v.n); i++) begin
         in_valid = 1'b1;
         in_data  = v.din[32*i +: 32];
         in_last  = (i == int'(v.n) - 1);
         @(negedge clk);
         if (i < int'(v.n) - 1) check("load_busy", busy, 1'b1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("issue_pulse", srt_x_valid, 1'b1);
      check("issue_x", srt_x, v.exp_x);
      check("issue_in_ready", in_ready, 1'b0);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
         check("wait_x_held", srt_x, v.exp_x);
         check("wait_no_pulse", srt_x_valid, 1'b0);
         check("wait_no_out", out_valid, 1'b0);
      end while (!srt_y_valid && guard < 20);
      if (!srt_y_valid) bound_fail("y_wait");
      k = 0; p = 0; guard = 0; stalled = 1'b0; prev = '0;
      @(negedge clk);
      while (k < int'(v.n) && guard < 60) begin
         if (stalled) check("stall_hold", out_data, prev);
         check("out_valid", out_valid, 1'b1);
         check("out_data", out_data, v.dout[32*k +: 32]);
         check("out_last", out_last, (k == int'(v.n) - 1));
         check("drain_in_ready", in_ready, 1'b0);
         out_ready = v.stall ? (p % 3 == 0) : 1'b1;
         prev      = out_data;
         stalled   = !out_ready;
         if (out_ready) k++;
         p++;
         guard++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      if (k < int'(v.n)) bound_fail("drain");
      check("done_out_valid", out_valid, 1'b0);
      check("done_busy", busy, 1'b0);
      check("done_in_ready", in_ready, 1'b1);
      check("done_pad", srt_x, PadU);
      check("timeout_err", timeout_err, exp_err);
      check("issue_count", xv_pulses - pulses0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{din: {32'd4, 32'd7, 32'd2, 32'd9}, n: 3'd4,
                  exp_x: {32'd4, 32'd7, 32'd2, 32'd9},
                  dout: {32'd9, 32'd7, 32'd4, 32'd2}, stall: 1'b0};
      vecs[1] = '{din: {32'd0, 32'd0, 32'd1, 32'd5}, n: 3'd2,
                  exp_x: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5},
                  dout: {32'd0, 32'd0, 32'd5, 32'd1}, stall: 1'b0};
      vecs[2] = '{din: {32'd3, 32'd0, 32'hFFFF_FFFF, 32'd3}, n: 3'd4,
                  exp_x: {32'd3, 32'd0, 32'hFFFF_FFFF, 32'd3},
                  dout: {32'hFFFF_FFFF, 32'd3, 32'd3, 32'd0}, stall: 1'b1};
      vecs[3] = '{din: {32'd0, 32'd0, 32'd0, 32'd6}, n: 3'd1,
                  exp_x: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6},
                  dout: {32'd0, 32'd0, 32'd0, 32'd6}, stall: 1'b0};
      vecs[4] = '{din: {32'd0, 32'd5, 32'd1, 32'd8}, n: 3'd3,
                  exp_x: {32'hFFFF_FFFF, 32'd5, 32'd1, 32'd8},
                  dout: {32'd0, 32'd8, 32'd5, 32'd1}, stall: 1'b1};
      vecs[5] = '{din: {32'd0, 32'd0, 32'd1, 32'd3}, n: 3'd2,
                  exp_x: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd3},
                  dout: {32'd0, 32'd0, 32'd3, 32'd1}, stall: 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_x_valid", srt_x_valid, 1'b0);
      check("rst_timeout", timeout_err, 1'b0);
      check("rst_pad_u", srt_x, PadU);
      check("rst_pad_s", s_srt_x, {4{32'h8000_0000}});

      // Signed descending: -3, 8 last.
      @(negedge clk);
      s_in_valid = 1'b1; s_in_data = 32'hFFFF_FFFD; s_in_last = 1'b0;
      @(negedge clk);
      s_in_data = 32'd8; s_in_last = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0; s_in_last = 1'b0;
      check("s_issue", s_srt_x_valid, 1'b1);
      check("s_x", s_srt_x, {32'h8000_0000, 32'h8000_0000, 32'd8, 32'hFFFF_FFFD});
      @(negedge clk);
      s_srt_y = {32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD, 32'd8};
      s_srt_y_valid = 1'b1;
      @(negedge clk);
      s_srt_y_valid = 1'b0;
      check("s_out0_valid", s_out_valid, 1'b1);
      check("s_out0_data", s_out_data, 32'd8);
      check("s_out0_last", s_out_last, 1'b0);
      @(negedge clk);
      check("s_out1_data", s_out_data, 32'hFFFF_FFFD);
      check("s_out1_last", s_out_last, 1'b1);
      @(negedge clk);
      check("s_done_valid", s_out_valid, 1'b0);
      check("s_done_busy", s_busy, 1'b0);

      for (int i = 0; i < 5; i++) run_batch(vecs[i], 1'b0);

      // Sorter never answers: timeout after 16 WAIT cycles.
      model_on = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check("to_issue", srt_x_valid, 1'b1);
      for (int w = 1; w <= 16; w++) begin
         @(negedge clk);
         check("to_err_early", timeout_err, 1'b0);
         check("to_busy", busy, 1'b1);
      end
      @(negedge clk);
      check("to_err_set", timeout_err, 1'b1);
      check("to_in_ready", in_ready, 1'b1);
      check("to_busy_low", busy, 1'b0);
      check("to_pad", srt_x, PadU);
      model_on = 1'b1;
      run_batch(vecs[5], 1'b1);

      // Reset while waiting; the late srt_y_valid must be ignored.
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'd2; in_last = 1'b0;
      @(negedge clk);
      in_data = 32'd1; in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check("r_issue", srt_x_valid, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("r_in_ready", in_ready, 1'b1);
      check("r_busy", busy, 1'b0);
      check("r_out_valid", out_valid, 1'b0);
      check("r_out_last", out_last, 1'b0);
      check("r_out_data", out_data, 32'd0);
      check("r_x_valid", srt_x_valid, 1'b0);
      check("r_timeout", timeout_err, 1'b0);
      check("r_pad", srt_x, PadU);
      @(negedge clk);
      if (!srt_y_valid) bound_fail("late_y");
      check("r_late_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("r_after_out_valid", out_valid, 1'b0);
      check("r_after_busy", busy, 1'b0);
      check("r_after_pad", srt_x, PadU);
      run_batch(vecs[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
